pomdp_trace_buf: RTL and testbench



---
 rtl/pomdp_trace_buf.sv | 133 +++++++++++++
 tb/tb_pomdp_trace_buf.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pomdp_trace_buf.sv
// Per-step POMDP trace buffer: reward delta + step tag into a show-ahead FIFO.
// Optional macro TRACE_OVERWRITE_EN: a write into a full FIFO overwrites the oldest entry.
module pomdp_trace_buf #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [1:0]       in_action,
    input  logic             in_observation,
    input  logic             in_state,
    input  logic [31:0]      in_reward,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [1:0]       out_action,
    output logic             out_observation,
    output logic             out_state,
    output logic [31:0]      out_delta,
    output logic [15:0]      out_step,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             overflow
);
    localparam int ENTRY_W = 52;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [15:0]      step_q, step_d;
    logic [31:0]      prev_q, prev_d;
    logic             ovf_q, ovf_d;
    logic             seen_q, seen_d;

    logic             wr_en, pop, inc, dec;
    logic [31:0]      delta;
    logic [ENTRY_W-1:0] entry, head;

    assign out_valid = (count_q != '0);
    assign full      = (count_q == DEPTH_C);
    assign count     = count_q;
    assign overflow  = ovf_q;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        step_d  = step_q;
        prev_d  = prev_q;
        ovf_d   = ovf_q;
        seen_d  = seen_q;
        wr_en   = 1'b0;
        inc     = 1'b0;
        dec     = 1'b0;
        delta   = in_reward - prev_q;
        entry   = {in_action, in_observation, in_state, delta, step_q};
        pop     = out_valid && out_ready;

        if (pop) begin
            rd_d = rd_q + 1'b1;
            dec  = 1'b1;
        end

        // Counter and reward history advance even when the entry is lost.
        if (in_valid) begin
            step_d = step_q + 16'd1;
            prev_d = in_reward;
            if (!full || pop) begin
                wr_en = 1'b1;
                inc   = 1'b1;
                wr_d  = wr_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
`ifdef TRACE_OVERWRITE_EN
                wr_en = 1'b1;
                wr_d  = wr_q + 1'b1;
                rd_d  = rd_q + 1'b1;
`endif
            end
        end

        if (inc && !dec)
            count_d = count_q + 1'b1;
        else if (dec && !inc)
            count_d = count_q - 1'b1;

        seen_d = seen_q | wr_en;

        if (clr) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
            step_d  = '0;
            prev_d  = '0;
            ovf_d   = 1'b0;
            seen_d  = 1'b0;
            wr_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            step_q  <= '0;
            prev_q  <= '0;
            ovf_q   <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            step_q  <= step_d;
            prev_q  <= prev_d;
            ovf_q   <= ovf_d;
            seen_q  <= seen_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_q] <= entry;
    end

    // Until something is written after reset/clr the storage is undefined, so outputs read zero.
    assign head = seen_q ? mem_q[rd_q] : '0;
    assign {out_action, out_observation, out_state, out_delta, out_step} = head;

endmodule

// File: tb/tb_pomdp_trace_buf.sv
// Directed, table-driven bench for pomdp_trace_buf (DEPTH = 16).
module tb_pomdp_trace_buf;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_action = '0;
    logic        in_observation = 1'b0;
    logic        in_state = 1'b0;
    logic [31:0] in_reward = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [1:0]  out_action;
    logic        out_observation;
    logic        out_state;
    logic [31:0] out_delta;
    logic [15:0] out_step;
    logic [4:0]  count;
    logic        full;
    logic        overflow;

    int nvec = 0;
    int nerr = 0;

    pomdp_trace_buf #(.DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_action(in_action), .in_observation(in_observation),
        .in_state(in_state), .in_reward(in_reward), .out_ready(out_ready),
        .out_valid(out_valid), .out_action(out_action), .out_observation(out_observation),
        .out_state(out_state), .out_delta(out_delta), .out_step(out_step),
        .count(count), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        iv;
        logic [1:0]  act;
        logic        obs;
        logic        st;
        logic [31:0] rew;
        logic        rdy;
        logic        e_valid;
        logic [15:0] e_step;
        logic [31:0] e_delta;
        logic [1:0]  e_act;
        logic        e_obs;
        logic        e_st;
        logic [4:0]  e_count;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic iv, input logic [1:0] a, input logic o,
                         input logic s, input logic [31:0] r, input logic rdy);
        clr = c; in_valid = iv; in_action = a; in_observation = o;
        in_state = s; in_reward = r; out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill16(input logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 2'(i), 1'(i), 1'(i >> 1), base + 32'(i), 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int first;
        // clr iv act obs st rew rdy | valid step delta act obs st count ovf
        vecs[0]  = '{0,0,2'd0,0,0,32'd0, 0,  0,16'd0,32'd0,2'd0,0,0,5'd0,0};
        vecs[1]  = '{0,1,2'd1,1,0,32'd5, 0,  1,16'd0,32'd5,2'd1,1,0,5'd1,0};
        vecs[2]  = '{0,1,2'd2,0,1,32'd5, 0,  1,16'd0,32'd5,2'd1,1,0,5'd2,0};
        vecs[3]  = '{0,1,2'd3,1,1,32'd12,0,  1,16'd0,32'd5,2'd1,1,0,5'd3,0};
        vecs[4]  = '{0,0,2'd0,0,0,32'd0, 1,  1,16'd1,32'd0,2'd2,0,1,5'd2,0};
        vecs[5]  = '{0,0,2'd0,0,0,32'd0, 1,  1,16'd2,32'd7,2'd3,1,1,5'd1,0};
        vecs[6]  = '{0,0,2'd0,0,0,32'd0, 1,  0,16'd0,32'd0,2'd0,0,0,5'd0,0};
        vecs[7]  = '{0,1,2'd0,0,0,32'h10,0,  1,16'd3,32'd4,2'd0,0,0,5'd1,0};
        vecs[8]  = '{0,1,2'd1,1,0,32'h08,1,  1,16'd4,32'hFFFF_FFF8,2'd1,1,0,5'd1,0};
        vecs[9]  = '{0,0,2'd0,0,0,32'd0, 1,  0,16'd0,32'd0,2'd0,0,0,5'd0,0};
        vecs[10] = '{0,1,2'd0,0,0,32'd20,0,  1,16'd5,32'd12,2'd0,0,0,5'd1,0};
        vecs[11] = '{0,1,2'd3,1,1,32'd21,0,  1,16'd5,32'd12,2'd0,0,0,5'd2,0};
        vecs[12] = '{0,1,2'd3,1,1,32'd22,0,  1,16'd5,32'd12,2'd0,0,0,5'd3,0};
        vecs[13] = '{0,1,2'd3,1,1,32'd23,0,  1,16'd5,32'd12,2'd0,0,0,5'd4,0};
        vecs[14] = '{1,1,2'd3,1,1,32'd99,1,  0,16'd0,32'd0,2'd0,0,0,5'd0,0};
        vecs[15] = '{0,1,2'd2,1,1,32'd50,0,  1,16'd0,32'd50,2'd2,1,1,5'd1,0};
        vecs[16] = '{1,0,2'd0,0,0,32'd0, 0,  0,16'd0,32'd0,2'd0,0,0,5'd0,0};

        #12;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_delta", out_delta, 0);
        chk("rst_step", 32'(out_step), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].clr, vecs[i].iv, vecs[i].act, vecs[i].obs, vecs[i].st,
                  vecs[i].rew, vecs[i].rdy);
            tick();
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_step", i), 32'(out_step), 32'(vecs[i].e_step));
                chk($sformatf("v%0d_delta", i), out_delta, vecs[i].e_delta);
                chk($sformatf("v%0d_act", i), 32'(out_action), 32'(vecs[i].e_act));
                chk($sformatf("v%0d_obs", i), 32'(out_observation), 32'(vecs[i].e_obs));
                chk($sformatf("v%0d_st", i), 32'(out_state), 32'(vecs[i].e_st));
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);

        // Fill then one extra strobe with no pop.
        fill16(0);
        chk("fill_count", 32'(count), 16);
        chk("fill_full", 32'(full), 1);
        chk("fill_ovf", 32'(overflow), 0);
        chk("fill_head", 32'(out_step), 0);
        drive(0, 1, 0, 0, 0, 32'd16, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("ovr_count", 32'(count), 16);
        chk("ovr_ovf", 32'(overflow), 1);
`ifdef TRACE_OVERWRITE_EN
        first = 1;
`else
        first = 0;
`endif
        chk("ovr_head", 32'(out_step), 32'(first));
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("ovr_drain%0d", k), 32'(out_step), 32'(first + k));
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        chk("ovr_empty", 32'(out_valid), 0);

        // Full FIFO with simultaneous write and pop.
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        fill16(100);
        chk("fp_head_before", 32'(out_step), 0);
        drive(0, 1, 2'd2, 1, 0, 32'd200, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("fp_count", 32'(count), 16);
        chk("fp_ovf", 32'(overflow), 0);
        chk("fp_head_after", 32'(out_step), 1);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("fp_drain%0d", k), 32'(out_step), 32'(k + 1));
            if (k == 15) chk("fp_tail_delta", out_delta, 32'd85);
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        chk("fp_empty", 32'(out_valid), 0);

        // Asynchronous reset mid-operation.
        drive(0, 1, 0, 0, 0, 32'd7, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("ar_pre_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_count", 32'(count), 0);
        #3 rst_n = 1'b1;
        tick();
        chk("ar_step", 32'(out_step), 0);
        chk("ar_valid2", 32'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
